pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the pong design. It sits between the VGA timing block (frame tick) and the ball/paddle update logic.
- Gates ball and paddle motion, holds and releases the ball for serves, keeps both scores, and declares the winner.
- All timing is counted in frames. Frame ticks come from the vsync-derived pulse.

Parameters:
- SERVE_FRAMES, 60, frame ticks the ball is held at centre before release (must be >= 1)
- POINT_FRAMES, 30, frame ticks the ball is frozen after a point (must be >= 1)
- WIN_SCORE, 9, score that ends the game (1..15)
- SCORE_W, $clog2(WIN_SCORE+1), score output width (derived, not overridden)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- frame_tick_i  in  1  one-cycle pulse per frame (start of vblank)
- start_i  in  1  debounced start button, level; rising edge detected internally
- miss_left_i  in  1  one-cycle pulse: ball passed the left paddle
- miss_right_i  in  1  one-cycle pulse: ball passed the right paddle
- ball_rst_o  out  1  hold ball at centre
- ball_en_o  out  1  ball may move this frame
- paddle_en_o  out  1  paddles may move
- serve_dir_o  out  1  initial ball x-direction: 1 = right, 0 = left
- score_l_o  out  SCORE_W  left player score
- score_r_o  out  SCORE_W  right player score
- game_over_o  out  1  game finished
- winner_o  out  1  0 = left won, 1 = right won; valid only while game_over_o=1
- state_o  out  3  current state encoding (debug/HUD)

Behaviour:
- All outputs are registered or decoded from registered state only. Any input event is reflected in the outputs the cycle after it is sampled.
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE, scores = 0, serve_dir_o = 1, frame counter = 0, start edge register = 0.
  - ball_rst_o = 1, ball_en_o = 0, paddle_en_o = 0, game_over_o = 0, winner_o = 0.
- Start edge: start_i registered each cycle. An edge is start_i=1 while the previous sample was 0.
- IDLE:
  - Outputs: ball_rst_o=1, paddle_en_o=0.
  - Start edge -> SERVE. Scores cleared, serve_dir_o=1, counter loaded with SERVE_FRAMES.
- SERVE:
  - Outputs: ball_rst_o=1, ball_en_o=0, paddle_en_o=1.
  - Counter decrements on each frame_tick_i. A tick arriving while the counter is 1 -> PLAY.
- PLAY:
  - Outputs: ball_rst_o=0, ball_en_o=1, paddle_en_o=1.
  - miss_left_i only: score_r += 1, serve_dir_o = 0 (serve toward the player who conceded), go to POINT, counter = POINT_FRAMES.
  - miss_right_i only: score_l += 1, serve_dir_o = 1, go to POINT.
  - Both in the same cycle: no score change, serve_dir_o unchanged, go to POINT.
- POINT:
  - Outputs: ball_en_o=0, ball_rst_o=0 (ball frozen in place), paddle_en_o=1.
  - Counter decrements on frame_tick_i. On expiry:
    - either score == WIN_SCORE -> OVER;
    - otherwise -> SERVE, counter = SERVE_FRAMES.
- OVER:
  - Outputs: game_over_o=1, winner_o=(score_r == WIN_SCORE), ball_rst_o=1, paddle_en_o=0. Scores are held.
  - Start edge -> SERVE with scores cleared and serve_dir_o=1.
- Ignored events:
  - miss pulses outside PLAY;
  - start edges in SERVE, PLAY and POINT;
  - frame_tick_i in IDLE, PLAY and OVER.
- Same-cycle events:
  - frame_tick_i together with a miss in PLAY: the miss is processed; the tick is not counted toward POINT.
  - Start edge in the same cycle as reset deassertion is lost. This is acceptable.
- Scores never exceed WIN_SCORE. No wrap is possible, because the game leaves PLAY once a score reaches WIN_SCORE.
- Reset mid-game: immediate return to IDLE with all reset values, whatever the state or counter.
- state_o encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Decomposition:
- pong_pkg holds:
  - typedef enum logic [2:0] game_state_t with the encoding above;
  - constants SERVE_RIGHT=1'b1 and SERVE_LEFT=1'b0;
  - the default frame counts.
- One sub-module, pong_frame_timer:
  - inputs: load, load value, frame_tick;
  - output: done pulse on the tick that expires the count;
  - counter width $clog2(max(SERVE_FRAMES, POINT_FRAMES)+1).

Test Plan (bench overrides SERVE_FRAMES=2, POINT_FRAMES=1, WIN_SCORE=3; frame_tick every 10 clocks):
- Reset release, no start for 100 clocks -> state_o=0, ball_rst_o=1, all enables 0, scores 0.
- Start pulse -> state_o=1 next cycle. After the 2nd frame tick -> state_o=2, ball_en_o=1, serve_dir_o=1.
- In PLAY, miss_left_i pulse -> next cycle score_r_o=1, serve_dir_o=0, state_o=3. After 1 tick -> state_o=1.
- miss_left_i and miss_right_i in the same cycle -> scores unchanged, state_o=3, serve_dir_o unchanged.
- Three miss_right_i points -> score_l_o=3, state_o=4, game_over_o=1, winner_o=0. Start edge -> scores 0, state_o=1.
- Assert rst_n_i low mid-PLAY with score_l_o=2 -> same-cycle async return to state_o=0, scores 0, ball_en_o=0. Miss pulses in SERVE produce no score change.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the pong game sequencer
//
// Contents:
//   game_state_t      : sequencer state, encoding is visible on state_o
//   SERVE_RIGHT/LEFT  : serve_dir_o values
//   DEF_*             : default frame counts and winning score
//   max_int()         : helper for sizing the frame counter
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam logic SERVE_RIGHT = 1'b1;
  localparam logic SERVE_LEFT  = 1'b0;

  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 30;
  localparam int DEF_WIN_SCORE    = 9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - loadable down-counter of frame ticks
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load count with load_val (takes priority over tick)
//   load_val   : frame count to load
//   tick       : frame tick, already qualified by the caller
//   done       : high on the tick that takes the count from 1 to 0
module pong_frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Combinational on purpose: the caller registers its state change on the
  // same edge, so the expiring tick is reflected one cycle later.
  assign done = tick && (count == CNT_W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: serve, play, point, game over
//
// Ports:
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   frame_tick_i              : one pulse per frame
//   start_i                   : start button level (rising edge starts a game)
//   miss_left_i, miss_right_i : ball passed the left / right paddle
//   ball_rst_o, ball_en_o     : hold ball at centre / let ball move
//   paddle_en_o               : paddles may move
//   serve_dir_o               : 1 = serve right, 0 = serve left
//   score_l_o, score_r_o      : player scores
//   game_over_o, winner_o     : game finished, 1 = right player won
//   state_o                   : current state encoding
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int   SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int   POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int   WIN_SCORE    = DEF_WIN_SCORE,
  localparam int  SCORE_W      = $clog2(WIN_SCORE + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               frame_tick_i,
  input  logic               start_i,
  input  logic               miss_left_i,
  input  logic               miss_right_i,
  output logic               ball_rst_o,
  output logic               ball_en_o,
  output logic               paddle_en_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_l_o,
  output logic [SCORE_W-1:0] score_r_o,
  output logic               game_over_o,
  output logic               winner_o,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  game_state_t state;
  logic        start_q;
  logic        start_edge;
  logic        any_miss;
  logic        timer_tick;
  logic        timer_load;
  logic [CNT_W-1:0] timer_val;
  logic        timer_done;

  assign start_edge = start_i && !start_q;
  assign any_miss   = miss_left_i || miss_right_i;

  // Frames only count while waiting out a serve or a point.
  assign timer_tick = frame_tick_i && ((state == ST_SERVE) || (state == ST_POINT));

  // Loading on POINT expiry into OVER is harmless: OVER ignores the timer.
  assign timer_load = (((state == ST_IDLE) || (state == ST_OVER)) && start_edge) ||
                      ((state == ST_PLAY) && any_miss) ||
                      ((state == ST_POINT) && timer_done);
  assign timer_val  = (state == ST_PLAY) ? CNT_W'(POINT_FRAMES) : CNT_W'(SERVE_FRAMES);

  pong_frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (timer_tick),
    .done     (timer_done)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      score_l_o   <= '0;
      score_r_o   <= '0;
      serve_dir_o <= SERVE_RIGHT;
      ball_rst_o  <= 1'b1;
      ball_en_o   <= 1'b0;
      paddle_en_o <= 1'b0;
      game_over_o <= 1'b0;
      winner_o    <= 1'b0;
    end else begin
      start_q <= start_i;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state       <= ST_SERVE;
            score_l_o   <= '0;
            score_r_o   <= '0;
            serve_dir_o <= SERVE_RIGHT;
            ball_rst_o  <= 1'b1;
            ball_en_o   <= 1'b0;
            paddle_en_o <= 1'b1;
            game_over_o <= 1'b0;
            winner_o    <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (timer_done) begin
            state      <= ST_PLAY;
            ball_rst_o <= 1'b0;
            ball_en_o  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (any_miss) begin
            state     <= ST_POINT;
            ball_en_o <= 1'b0;
            // A double miss is a dead ball: nobody scores, serve unchanged.
            if (miss_left_i && !miss_right_i) begin
              score_r_o   <= score_r_o + SCORE_W'(1);
              serve_dir_o <= SERVE_LEFT;
            end else if (miss_right_i && !miss_left_i) begin
              score_l_o   <= score_l_o + SCORE_W'(1);
              serve_dir_o <= SERVE_RIGHT;
            end
          end
        end
        ST_POINT: begin
          if (timer_done) begin
            ball_rst_o <= 1'b1;
            if ((score_l_o == WIN_VAL) || (score_r_o == WIN_VAL)) begin
              state       <= ST_OVER;
              paddle_en_o <= 1'b0;
              game_over_o <= 1'b1;
              winner_o    <= (score_r_o == WIN_VAL);
            end else begin
              state <= ST_SERVE;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          ball_rst_o  <= 1'b1;
          ball_en_o   <= 1'b0;
          paddle_en_o <= 1'b0;
          game_over_o <= 1'b0;
          winner_o    <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic       ball_rst;
  logic       ball_en;
  logic       paddle_en;
  logic       serve_dir;
  logic [1:0] score_l;
  logic [1:0] score_r;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl #(
    .SERVE_FRAMES (2),
    .POINT_FRAMES (1),
    .WIN_SCORE    (3)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .frame_tick_i (frame_tick),
    .start_i      (start),
    .miss_left_i  (miss_left),
    .miss_right_i (miss_right),
    .ball_rst_o   (ball_rst),
    .ball_en_o    (ball_en),
    .paddle_en_o  (paddle_en),
    .serve_dir_o  (serve_dir),
    .score_l_o    (score_l),
    .score_r_o    (score_r),
    .game_over_o  (game_over),
    .winner_o     (winner),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Nine quiet cycles then a one-cycle tick: one frame every 10 clocks.
  task automatic frame();
    repeat (9) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic pulse(input logic ml, input logic mr, input logic tk);
    miss_left  = ml;
    miss_right = mr;
    frame_tick = tk;
    @(negedge clk);
    miss_left  = 1'b0;
    miss_right = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 8'(state), 8'd0);
    check("rst_ball_rst", 8'(ball_rst), 8'd1);
    check("rst_serve_dir", 8'(serve_dir), 8'd1);
    rst_n = 1'b1;

    // Idle for 100 clocks with ticks: nothing moves.
    repeat (10) frame();
    check("idle_state", 8'(state), 8'd0);
    check("idle_ball_rst", 8'(ball_rst), 8'd1);
    check("idle_ball_en", 8'(ball_en), 8'd0);
    check("idle_paddle_en", 8'(paddle_en), 8'd0);
    check("idle_game_over", 8'(game_over), 8'd0);
    check("idle_scores", {4'(score_l), 4'(score_r)}, 8'h00);

    start_pulse();
    check("start_state", 8'(state), 8'd1);
    check("start_paddle_en", 8'(paddle_en), 8'd1);
    check("start_ball_rst", 8'(ball_rst), 8'd1);
    frame();
    check("serve_tick1_state", 8'(state), 8'd1);
    frame();
    check("serve_done_state", 8'(state), 8'd2);
    check("play_ball_en", 8'(ball_en), 8'd1);
    check("play_ball_rst", 8'(ball_rst), 8'd0);
    check("play_serve_dir", 8'(serve_dir), 8'd1);

    pulse(1'b1, 1'b0, 1'b0);
    check("ml_score_r", 8'(score_r), 8'd1);
    check("ml_score_l", 8'(score_l), 8'd0);
    check("ml_serve_dir", 8'(serve_dir), 8'd0);
    check("ml_state", 8'(state), 8'd3);
    check("point_ball_en", 8'(ball_en), 8'd0);
    check("point_ball_rst", 8'(ball_rst), 8'd0);
    frame();
    check("point_exp_state", 8'(state), 8'd1);
    check("reserve_ball_rst", 8'(ball_rst), 8'd1);

    // Misses while serving are ignored.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("serve_miss_scores", {4'(score_l), 4'(score_r)}, 8'h01);
    check("serve_miss_state", 8'(state), 8'd1);
    frame();
    frame();
    check("play2_state", 8'(state), 8'd2);

    pulse(1'b1, 1'b1, 1'b0);
    check("both_scores", {4'(score_l), 4'(score_r)}, 8'h01);
    check("both_state", 8'(state), 8'd3);
    check("both_serve_dir", 8'(serve_dir), 8'd0);
    frame();
    check("both_exp_state", 8'(state), 8'd1);

    // Three right-side misses; the first coincides with a frame tick.
    for (int p = 1; p <= 3; p++) begin
      frame();
      frame();
      check("rp_play_state", 8'(state), 8'd2);
      pulse(1'b0, 1'b1, (p == 1));
      check("rp_score_l", 8'(score_l), 8'(p));
      check("rp_serve_dir", 8'(serve_dir), 8'd1);
      check("rp_point_state", 8'(state), 8'd3);
      frame();
    end
    check("over_state", 8'(state), 8'd4);
    check("over_game_over", 8'(game_over), 8'd1);
    check("over_winner", 8'(winner), 8'd0);
    check("over_ball_rst", 8'(ball_rst), 8'd1);
    check("over_paddle_en", 8'(paddle_en), 8'd0);
    check("over_scores", {4'(score_l), 4'(score_r)}, 8'h31);
    pulse(1'b0, 1'b1, 1'b0);
    check("over_miss_score_l", 8'(score_l), 8'd3);

    start_pulse();
    check("restart_state", 8'(state), 8'd1);
    check("restart_scores", {4'(score_l), 4'(score_r)}, 8'h00);
    check("restart_game_over", 8'(game_over), 8'd0);
    check("restart_serve_dir", 8'(serve_dir), 8'd1);

    // Reach PLAY with score_l = 2, then reset mid-rally.
    for (int p = 1; p <= 2; p++) begin
      frame();
      frame();
      pulse(1'b0, 1'b1, 1'b0);
      frame();
    end
    frame();
    frame();
    check("prerst_state", 8'(state), 8'd2);
    check("prerst_score_l", 8'(score_l), 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 8'(state), 8'd0);
    check("async_scores", {4'(score_l), 4'(score_r)}, 8'h00);
    check("async_ball_en", 8'(ball_en), 8'd0);
    check("async_ball_rst", 8'(ball_rst), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    check("post_rst_state", 8'(state), 8'd1);
    pulse(1'b1, 1'b0, 1'b0);
    check("post_rst_serve_miss", {4'(score_l), 4'(score_r)}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
